// File: rtl/dsp_pkg.sv
// Shared definitions for the sequential dot-product block: FSM states and
// elaboration-time width helpers.
package dsp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Wide enough that N full-width products can never wrap inside one run.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply lane: WIDTH x WIDTH product, zero when the lane is disabled.
module mac_lane #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               en,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  // The low 2*WIDTH bits of an extended multiply are correct for both
  // two's-complement and unsigned operands.
  assign a_ext = {{WIDTH{SIGNED & a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{SIGNED & b[WIDTH-1]}}, b};
  assign prod  = en ? a_ext * b_ext : '0;

endmodule

// File: rtl/dot_product_seq.sv
// Resource-shared dot product: LANES multiply-accumulate lanes iterate over an
// N-element vector pair, with chaining across runs and an overflow flag.
module dot_product_seq
  import dsp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N      = 5,
  parameter int LANES  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               acc_mode,
  input  logic [N*WIDTH-1:0] a_flat,
  input  logic [N*WIDTH-1:0] b_flat,
  output logic [WIDTH-1:0]   x,
  output logic               ovf,
  output logic               valid,
  output logic               busy
);

  localparam int ACC_W = acc_width(WIDTH, N);
  localparam int PW    = 2 * WIDTH;
  localparam int K     = (N + LANES - 1) / LANES;
  localparam int GW    = (clog2(K) > 0) ? clog2(K) : 1;

  state_t             state;
  state_t             state_next;
  logic [N*WIDTH-1:0] a_sr;
  logic [N*WIDTH-1:0] b_sr;
  logic [GW-1:0]      grp;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [PW-1:0]      prod [LANES];
  logic [LANES-1:0]   lane_en;
  logic               last_grp;
  logic               load;
  logic               acc_ovf;

  assign last_grp = (grp == GW'(K - 1));
  assign load     = start && (state != RUN);
  assign valid    = (state == DONE);
  assign busy     = (state == RUN);

  // Lane j always reads element j of the shift registers; lanes past the end
  // of the vector in a ragged last group are disabled.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_en[j] = ((int'(grp) * LANES + j) < N);

    mac_lane #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_mac (
      .a    (a_sr[j*WIDTH +: WIDTH]),
      .b    (b_sr[j*WIDTH +: WIDTH]),
      .en   (lane_en[j]),
      .prod (prod[j])
    );
  end

  always_comb begin
    acc_sum = acc;
    for (int j = 0; j < LANES; j++) begin
      acc_sum = acc_sum + {{(ACC_W - PW){SIGNED & prod[j][PW-1]}}, prod[j]};
    end
  end

  // Signed: every bit from WIDTH-1 upward must equal the sign bit.
  always_comb begin
    if (SIGNED) begin
      acc_ovf = !((&acc_sum[ACC_W-1:WIDTH-1]) || (~|acc_sum[ACC_W-1:WIDTH-1]));
    end else begin
      acc_ovf = |acc_sum[ACC_W-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_grp) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sr <= '0;
      b_sr <= '0;
      grp  <= '0;
      acc  <= '0;
      x    <= '0;
      ovf  <= '0;
    end else if (load) begin
      a_sr <= a_flat;
      b_sr <= b_flat;
      grp  <= '0;
      if (!acc_mode) acc <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> (LANES * WIDTH);
      b_sr <= b_sr >> (LANES * WIDTH);
      grp  <= grp + GW'(1);
      acc  <= acc_sum;
      if (last_grp) begin
        x   <= acc_sum[WIDTH-1:0];
        ovf <= acc_ovf;
      end
    end
  end

endmodule

// File: doc/dot_product_seq.md
# dot_product_seq

Parametrised, resource-shared successor to the fully unrolled multiply/add chain. The block computes x = Σ a_i·b_i over N element pairs using LANES multiply-accumulate lanes, iterating over the vector instead of instantiating N multipliers and N adders. It keeps the existing start/valid/busy handshake, so the Python-to-Verilog generator can emit it in place of an unrolled loop when area matters more than latency. It adds signed operation, chained accumulation across runs and an overflow flag.

## Interface
- WIDTH, 32: element and result width in bits.
- N, 5: vector length, ≥1.
- LANES, 1: products accumulated per cycle, 1..N.
- SIGNED, 0: 1 = two's-complement operands, 0 = unsigned.
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the block can accept.
- acc_mode  in  1  sampled with start: 0 = accumulator starts at 0; 1 = accumulator starts at the current full-precision accumulator (chaining).
- a_flat  in  N·WIDTH  operand vector; element i is bits [i·WIDTH +: WIDTH]. Sampled with start.
- b_flat  in  N·WIDTH  operand vector, same packing as a_flat.
- x  out  WIDTH  result, low WIDTH bits of the accumulator.
- ovf  out  1  accumulator value is not representable in WIDTH bits (signedness per SIGNED).
- valid  out  1  single-cycle pulse; x and ovf are final.
- busy  out  1  computation in progress.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch a_flat and b_flat. Load the accumulator with 0, or with the held accumulator if acc_mode=1. Clear the group index. Go to RUN.
- RUN: each cycle, add LANES products for elements g·LANES .. g·LANES+LANES−1. In the last group, lanes with index ≥ N contribute 0.
  - After group K−1, where K = ceil(N/LANES), go to DONE.
- DONE: valid=1 for exactly this cycle. Next state is RUN if start=1 (back-to-back), otherwise IDLE.
- start while in RUN: ignored. Operand and acc_mode changes during RUN have no effect.
- Arithmetic:
  - Products are 2·WIDTH bits.
  - Accumulator ACC_W = 2·WIDTH + clog2(N+1) bits, sign- or zero-extended per SIGNED. No internal wrap within a run.
  - Chained runs wrap modulo 2^ACC_W.
- x = acc[WIDTH−1:0].
- ovf = 1 when acc is out of range:
  - SIGNED=1: outside −2^(WIDTH−1) .. 2^(WIDTH−1)−1.
  - SIGNED=0: outside 0 .. 2^WIDTH−1.
- x and ovf update only on entering DONE. They hold until the next DONE or reset.

## Timing
- Reset (reset=0, asynchronous) clears all of the following: state=IDLE, x=0, ovf=0, valid=0, busy=0, accumulator=0.
  - Reset mid-run aborts the run. No valid is produced.
- The clock edge that samples start is E0. busy=1 after E0. Accumulation edges are E1..EK. After EK: valid=1, busy=0.
  - Latency from start to valid is K edges. Example: N=5, LANES=1 gives 5.
- Back-to-back: start high during the DONE cycle gives busy=1 on the next cycle. Throughput is one result per K+1 cycles.
- busy and valid are never high in the same cycle.

## Structure
- Shared package dsp_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - an ACC_W computation function;
  - a clog2 helper.
- Sub-module mac_lane: one WIDTH×WIDTH multiply with a SIGNED mode and an enable. It outputs a 2·WIDTH product, forced to 0 when enable=0.
  - The top level instantiates LANES copies with a generate loop and sums them into the accumulator.
- Operand registers are shifted down by LANES elements per RUN cycle, so lane j always reads element j of the shift register. This means no wide multiplexer is needed.

## Test plan
- N=5, LANES=1, unsigned: a={1,2,3,4,5}, b={6,7,8,9,10}, start for 1 cycle → x=130, ovf=0. valid pulses exactly 5 edges after start; busy is high for 5 cycles.
- Same vectors with LANES=2 → x=130 after 3 edges; the ragged last lane contributes 0. With LANES=5 → x=130 after 1 edge.
- SIGNED=1: a={−3,2,0,7,−1}, b={4,−5,9,1,−8} → x=−7 (0xFFFF_FFF9), ovf=0.
- Chaining: run the first vector set (x=130), then start with acc_mode=1 and the same vectors → x=260.
- Unsigned overflow: all a_i=b_i=0xFFFF_FFFF → ovf=1, x = low 32 bits of the exact sum (0x0000_0005). Signed overflow with a_i=b_i=0x8000_0000 → ovf=1.
- Robustness:
  - start pulsed during RUN → ignored; the original result arrives on schedule.
  - start held high through DONE → back-to-back run.
  - reset driven low at E2 → all outputs 0 immediately; no valid occurs; the next start after release gives a correct result.
